// File: rtl/tx_serial_8n1.sv
// 8N1 UART transmitter: one byte per start pulse, LSB first, CLKS_PER_BIT clocks per bit.
// Latency: the line falls on the same edge that samples partida; frame lasts 10*CLKS_PER_BIT cycles plus a one-cycle FINAL.
// Backpressure: ocupado high while a frame is on the line; partida is ignored then (no queueing).
module tx_serial_8n1 #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dados,
    output logic       saida_serial,
    output logic       ocupado,
    output logic       pronto
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        REPOUSO,
        PARTIDA,
        DADOS,
        PARADA,
        FINAL
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             bit_end;

    assign bit_end = (baud_cnt == CNT_LAST);

    // Outputs are written alongside the state so they reflect the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= REPOUSO;
            saida_serial <= 1'b1;
            ocupado      <= 1'b0;
            pronto       <= 1'b0;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
        end else begin
            case (state)
                REPOUSO, FINAL: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    pronto   <= 1'b0;
                    if (partida) begin
                        shift_reg    <= dados;
                        state        <= PARTIDA;
                        saida_serial <= 1'b0;
                        ocupado      <= 1'b1;
                    end else begin
                        state        <= REPOUSO;
                        saida_serial <= 1'b1;
                        ocupado      <= 1'b0;
                    end
                end

                PARTIDA: begin
                    if (bit_end) begin
                        state        <= DADOS;
                        baud_cnt     <= '0;
                        bit_idx      <= '0;
                        saida_serial <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                DADOS: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state        <= PARADA;
                            bit_idx      <= '0;
                            saida_serial <= 1'b1;
                        end else begin
                            bit_idx      <= bit_idx + 3'd1;
                            saida_serial <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                PARADA: begin
                    if (bit_end) begin
                        state        <= FINAL;
                        baud_cnt     <= '0;
                        saida_serial <= 1'b1;
                        ocupado      <= 1'b0;
                        pronto       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state        <= REPOUSO;
                    saida_serial <= 1'b1;
                    ocupado      <= 1'b0;
                    pronto       <= 1'b0;
                    baud_cnt     <= '0;
                    bit_idx      <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/tx_serial_8n1.md
# tx_serial_8N1

UART transmitter, 8 data bits, no parity, 1 stop bit (8N1), LSB first. It is the transmit-side counterpart of the project's serial receiver. It takes a byte on a one-cycle start pulse and shifts it out on `saida_serial` at the baud set by `CLKS_PER_BIT`. It reports busy and completion so an upstream controller, for example one echoing the received ASCII digit, can chain frames back to back.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200 baud). Must be ≥ 2.
- `clock` in 1: single system clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high. Forces the idle state and outputs immediately.
- `partida` in 1: start request, sampled on the rising edge. Accepted only in REPOUSO or FINAL.
- `dados` in 8: byte to transmit. Latched into an internal shift register on the accepting edge; may change afterwards.
- `saida_serial` out 1: serial line, registered. Idles high.
- `ocupado` out 1: high while a frame is on the line (PARTIDA, DADOS, PARADA).
- `pronto` out 1: one-cycle pulse after the stop bit completes (state FINAL).

## Operation
- States: REPOUSO, PARTIDA, DADOS, PARADA, FINAL. Encoding is free.
- Reset values: state REPOUSO, `saida_serial`=1, `ocupado`=0, `pronto`=0, baud counter 0, bit index 0, shift register 0x00.
- REPOUSO: line = 1. If `partida`=1, latch `dados` and go to PARTIDA. Otherwise stay.
- PARTIDA: line = 0 for CLKS_PER_BIT cycles, then go to DADOS with bit index 0.
- DADOS: line = `dados_latched[bit index]`, held for CLKS_PER_BIT cycles per bit.
  - Bit index increments after each bit period.
  - After bit 7's period completes, go to PARADA.
- PARADA: line = 1 for CLKS_PER_BIT cycles, then go to FINAL.
- FINAL: exactly one cycle. Line = 1, `pronto`=1, `ocupado`=0.
  - `partida`=1 here latches new `dados` and goes to PARTIDA (back-to-back operation).
  - Otherwise go to REPOUSO.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets to 0 on every state or bit change. Width is clog2(CLKS_PER_BIT).
- `partida` in PARTIDA, DADOS or PARADA is ignored. There is no queueing, and the latched byte is not altered.
- `dados` changes during a frame have no effect on the frame in progress.
- Reset mid-frame: frame aborted, line returns high asynchronously, no `pronto` pulse.

## Timing
- Latency: `partida` sampled at edge E0, so `saida_serial` falls and `ocupado` rises at edge E0.
  - Outputs are registered and decoded from the next state.
- Start bit occupies edges E0 … E0+CLKS_PER_BIT-1.
- Data bit k begins at edge E0 + (k+1)·CLKS_PER_BIT.
- Stop bit begins at E0 + 9·CLKS_PER_BIT.
- `pronto`=1 and `ocupado`=0 during the single cycle starting at E0 + 10·CLKS_PER_BIT.
- Frame length on the line: 10·CLKS_PER_BIT cycles (start + 8 data + stop).
- Back-to-back: with `partida` held high in FINAL, the line shows the stop bit, then one extra high cycle, then the next start bit.
  - Frame period = 10·CLKS_PER_BIT + 1 cycles.
- `pronto` is never high in the same cycle as `ocupado`.

## Test plan
Simulate with `CLKS_PER_BIT`=4 unless noted.
- **Reset/idle.** Assert `reset` mid-simulation, asynchronously between edges. Required: `saida_serial`=1, `ocupado`=0 and `pronto`=0 immediately. The line stays high with no `partida`.
- **Single frame.** `dados`=0x35 (ASCII '5'), `partida` pulsed for 1 cycle. Required bits on the line, each held 4 cycles: 0,1,0,1,0,1,1,0,0,1. `ocupado` high for 40 cycles, then `pronto` high for exactly 1 cycle.
- **Loopback.** `CLKS_PER_BIT`=434, `saida_serial` wired to the project receiver. Send 0x30, 0x39 and 0xA5. Required: the receiver's data-valid strobe fires once per frame, and the received byte equals the sent byte.
- **Ignored start and unstable data.** During frame 0x35, pulse `partida` at cycle 12 with `dados`=0xFF. Required: frame 0x35 is unchanged, and no second frame follows.
- **Back-to-back.** Hold `partida`=1 with 0x55, then 0xAA presented at FINAL. Required: the second start bit begins 41 cycles after the first.
- **Reset mid-frame.** Assert `reset` during data bit 3 of 0x0F. Required: the line goes high at once, and `pronto` never pulses. After release, a new `partida` with 0x0F produces a full correct frame.
